// File: rtl/flag_unit.sv
// Architectural Z/V/N flag register, branch-condition evaluation and sticky halt.
// Sits after the ALU; flags update one cycle after a qualifying result.
module flag_unit #(
    parameter bit BYPASS = 1'b0,
    parameter int WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic             stall,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovfl,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    output logic [2:0]       flags,
    output logic             br_taken,
    output logic             halted
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic       upd;
    logic       write_all;
    logic       write_z;
    logic       result_zero;
    logic [2:0] flags_next;
    logic [2:0] flags_eff;
    logic       cond_met;

    assign upd         = alu_valid & ~stall & ~halted;
    assign result_zero = (alu_result == '0);

    always_comb begin
        write_all = 1'b0;
        write_z   = 1'b0;
        if (upd) begin
            case (opcode)
                OP_ADD, OP_SUB:                 write_all = 1'b1;
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: write_z   = 1'b1;
                default: ;
            endcase
        end
    end

    // Flag layout is {Z,V,N}; logic ops only touch Z.
    always_comb begin
        flags_next = flags;
        if (write_all) begin
            flags_next = {result_zero, alu_ovfl, alu_result[WIDTH-1]};
        end else if (write_z) begin
            flags_next[2] = result_zero;
        end
    end

    assign flags_eff = (BYPASS && (write_all || write_z)) ? flags_next : flags;

    always_comb begin
        cond_met = 1'b0;
        case (br_cond)
            3'b000:  cond_met = ~flags_eff[2];
            3'b001:  cond_met = flags_eff[2];
            3'b010:  cond_met = ~flags_eff[2] & ~flags_eff[0];
            3'b011:  cond_met = flags_eff[0];
            3'b100:  cond_met = flags_eff[2] | (~flags_eff[2] & ~flags_eff[0]);
            3'b101:  cond_met = flags_eff[0] | flags_eff[2];
            3'b110:  cond_met = flags_eff[1];
            default: cond_met = 1'b1;
        endcase
    end

    assign br_taken = br_valid & ~halted & cond_met;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags  <= 3'b000;
            halted <= 1'b0;
        end else begin
            flags <= flags_next;
            if (upd && (opcode == OP_HLT)) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: one instance per BYPASS setting, compared
// against a behavioural model of the flag and branch rules.
module tb_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        stall;
    logic [3:0]  opcode;
    logic [15:0] alu_result;
    logic        alu_ovfl;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [2:0]  flags0, flags1;
    logic        br_taken0, br_taken1;
    logic        halted0, halted1;

    int total = 0;
    int bad   = 0;

    logic [2:0] m_flags;
    logic       m_halt;

    always #5 clk = ~clk;

    flag_unit #(.BYPASS(1'b0), .WIDTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .stall(stall),
        .opcode(opcode), .alu_result(alu_result), .alu_ovfl(alu_ovfl),
        .br_valid(br_valid), .br_cond(br_cond),
        .flags(flags0), .br_taken(br_taken0), .halted(halted0)
    );

    flag_unit #(.BYPASS(1'b1), .WIDTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .stall(stall),
        .opcode(opcode), .alu_result(alu_result), .alu_ovfl(alu_ovfl),
        .br_valid(br_valid), .br_cond(br_cond),
        .flags(flags1), .br_taken(br_taken1), .halted(halted1)
    );

    // Flags as they will be after the coming edge, from the opcode-class rules.
    function automatic logic [2:0] model_next(input logic [2:0] f, input logic h);
        logic [2:0] r;
        r = f;
        if (alu_valid && !stall && !h) begin
            if (opcode inside {4'd0, 4'd1})
                r = {alu_result == 16'h0, alu_ovfl, alu_result[15]};
            else if (opcode inside {4'd2, 4'd4, 4'd5, 4'd6})
                r[2] = (alu_result == 16'h0);
        end
        return r;
    endfunction

    function automatic logic model_cond(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic model_br(input bit bypass);
        if (!br_valid || m_halt) return 1'b0;
        return model_cond(br_cond, bypass ? model_next(m_flags, m_halt) : m_flags);
    endfunction

    task automatic tick();
        logic [2:0] nf;
        logic       nh;
        nf = model_next(m_flags, m_halt);
        nh = m_halt | (alu_valid && !stall && !m_halt && opcode == 4'hF);
        @(posedge clk);
        #1;
        m_flags = nf;
        m_halt  = nh;
    endtask

    task automatic idle();
        alu_valid = 1'b0; stall = 1'b0; br_valid = 1'b0;
        opcode = 4'h0; alu_result = 16'h0; alu_ovfl = 1'b0; br_cond = 3'd0;
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [15:0] res, input logic ov);
        alu_valid = 1'b1; opcode = op; alu_result = res; alu_ovfl = ov;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        m_flags = 3'b000; m_halt = 1'b0;
        #12;
        total++;
        if (flags0 !== 3'b000 || flags1 !== 3'b000) begin
            bad++; $display("[TB] FAIL reset_flags: got %b/%b expected 000", flags0, flags1);
        end
        total++;
        if (halted0 !== 1'b0 || br_taken0 !== 1'b0 || br_taken1 !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_halt_br: got halted=%b br=%b/%b expected 0", halted0, br_taken0, br_taken1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_zero();
        alu_op(4'h0, 16'h0000, 1'b0);
        tick();
        idle();
        total++;
        if (flags0 !== 3'b100 || flags1 !== 3'b100) begin
            bad++; $display("[TB] FAIL add_zero_flags: got %b/%b expected 100", flags0, flags1);
        end
        br_valid = 1'b1; br_cond = 3'b001;
        #1;
        total++;
        if (br_taken0 !== 1'b1 || br_taken1 !== 1'b1) begin
            bad++; $display("[TB] FAIL add_zero_eq: got %b/%b expected 1", br_taken0, br_taken1);
        end
        br_cond = 3'b000;
        #1;
        total++;
        if (br_taken0 !== 1'b0 || br_taken1 !== 1'b0) begin
            bad++; $display("[TB] FAIL add_zero_ne: got %b/%b expected 0", br_taken0, br_taken1);
        end
        idle();
    endtask

    task automatic test_sub_xor_red();
        alu_op(4'h1, 16'h8000, 1'b1);
        tick();
        total++;
        if (flags0 !== 3'b011) begin
            bad++; $display("[TB] FAIL sub_flags: got %b expected 011", flags0);
        end
        alu_op(4'h2, 16'h0000, 1'b0);
        tick();
        total++;
        if (flags0 !== 3'b111) begin
            bad++; $display("[TB] FAIL xor_flags: got %b expected 111", flags0);
        end
        alu_op(4'h3, 16'h0000, 1'b0);
        tick();
        total++;
        if (flags0 !== 3'b111 || flags1 !== 3'b111) begin
            bad++; $display("[TB] FAIL red_hold: got %b/%b expected 111", flags0, flags1);
        end
        idle();
    endtask

    task automatic test_cond_sweep();
        logic [15:0] res [4] = '{16'h0001, 16'h0000, 16'h8000, 16'h7FFF};
        logic        ovf [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  exp [4] = '{3'b000, 3'b100, 3'b001, 3'b010};
        for (int p = 0; p < 4; p++) begin
            alu_op(4'h0, res[p], ovf[p]);
            tick();
            idle();
            total++;
            if (flags0 !== exp[p]) begin
                bad++; $display("[TB] FAIL sweep_flags%0d: got %b expected %b", p, flags0, exp[p]);
            end
            br_valid = 1'b1;
            for (int c = 0; c < 8; c++) begin
                br_cond = 3'(c);
                #1;
                total++;
                if (br_taken0 !== model_cond(3'(c), exp[p]) || br_taken1 !== model_cond(3'(c), exp[p])) begin
                    bad++; $display("[TB] FAIL sweep_br p%0d c%0d: got %b/%b expected %b",
                                    p, c, br_taken0, br_taken1, model_cond(3'(c), exp[p]));
                end
            end
            idle();
        end
    endtask

    task automatic test_bypass_stall();
        alu_op(4'h0, 16'h0001, 1'b0);
        tick();
        alu_op(4'h0, 16'h0000, 1'b0);
        br_valid = 1'b1; br_cond = 3'b001;
        #1;
        total++;
        if (br_taken1 !== 1'b1) begin
            bad++; $display("[TB] FAIL bypass_on: got %b expected 1", br_taken1);
        end
        total++;
        if (br_taken0 !== 1'b0) begin
            bad++; $display("[TB] FAIL bypass_off: got %b expected 0", br_taken0);
        end
        tick();
        total++;
        if (flags0 !== 3'b100 || flags1 !== 3'b100) begin
            bad++; $display("[TB] FAIL bypass_flags: got %b/%b expected 100", flags0, flags1);
        end
        alu_op(4'h1, 16'h8000, 1'b1);
        stall = 1'b1; br_cond = 3'b011;
        #1;
        total++;
        if (br_taken0 !== 1'b0 || br_taken1 !== 1'b0) begin
            bad++; $display("[TB] FAIL stall_bypass: got %b/%b expected 0", br_taken0, br_taken1);
        end
        tick();
        total++;
        if (flags0 !== 3'b100 || flags1 !== 3'b100) begin
            bad++; $display("[TB] FAIL stall_hold: got %b/%b expected 100", flags0, flags1);
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            alu_valid  = 1'($urandom_range(0, 1));
            stall      = ($urandom_range(0, 7) == 0);
            opcode     = 4'($urandom_range(0, 14));
            alu_result = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            alu_ovfl   = 1'($urandom_range(0, 1));
            br_valid   = 1'($urandom_range(0, 1));
            br_cond    = 3'($urandom_range(0, 7));
            #1;
            total++;
            if (br_taken0 !== model_br(1'b0) || br_taken1 !== model_br(1'b1)) begin
                bad++; $display("[TB] FAIL rand_br%0d: got %b/%b expected %b/%b",
                                i, br_taken0, br_taken1, model_br(1'b0), model_br(1'b1));
            end
            tick();
            total++;
            if (flags0 !== m_flags || flags1 !== m_flags || halted0 !== m_halt) begin
                bad++; $display("[TB] FAIL rand_flags%0d: got %b/%b h=%b expected %b h=%b",
                                i, flags0, flags1, halted0, m_flags, m_halt);
            end
        end
        idle();
    endtask

    task automatic test_halt();
        alu_op(4'h1, 16'h8000, 1'b1);
        tick();
        alu_op(4'h2, 16'h0000, 1'b0);
        tick();
        alu_op(4'hF, 16'h1234, 1'b0);
        tick();
        total++;
        if (halted0 !== 1'b1 || halted1 !== 1'b1) begin
            bad++; $display("[TB] FAIL halt_set: got %b/%b expected 1", halted0, halted1);
        end
        alu_op(4'h0, 16'h0001, 1'b0);
        br_valid = 1'b1; br_cond = 3'b111;
        #1;
        total++;
        if (br_taken0 !== 1'b0 || br_taken1 !== 1'b0) begin
            bad++; $display("[TB] FAIL halt_br: got %b/%b expected 0", br_taken0, br_taken1);
        end
        tick();
        total++;
        if (flags0 !== 3'b111 || flags1 !== 3'b111 || halted0 !== 1'b1) begin
            bad++; $display("[TB] FAIL halt_hold: got %b/%b h=%b expected 111 h=1", flags0, flags1, halted0);
        end
        idle();
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        m_flags = 3'b000; m_halt = 1'b0;
        total++;
        if (flags0 !== 3'b000 || flags1 !== 3'b000 || halted0 !== 1'b0 || halted1 !== 1'b0) begin
            bad++; $display("[TB] FAIL async_reset: got %b/%b h=%b/%b expected 000 h=0",
                            flags0, flags1, halted0, halted1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        alu_op(4'h0, 16'h0000, 1'b0);
        tick();
        total++;
        if (flags0 !== 3'b100 || halted0 !== 1'b0) begin
            bad++; $display("[TB] FAIL post_reset_add: got %b h=%b expected 100 h=0", flags0, halted0);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_add_zero();
        test_sub_xor_red();
        test_cond_sweep();
        test_bypass_stall();
        test_random();
        test_halt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Sits directly downstream of the ALU and its reduction and packed-add lanes.
- Consumes the 16-bit ALU result and the overflow indication, and holds the architectural Z/V/N flag register.
- Updates flags per opcode class and evaluates the 3-bit branch condition for B/BR.
- Also latches HLT so the fetch stage stops issuing.

Parameters:
- BYPASS, 0: when 1, branch evaluation sees flags being written in the same cycle; when 0, it uses registered flags only.
- WIDTH, 16: ALU result width. Only 16 is supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU result and opcode are valid this cycle.
- stall  input  1  pipeline stall; blocks every state update.
- opcode  input  4  opcode of the instruction producing alu_result.
- alu_result  input  WIDTH  ALU output.
- alu_ovfl  input  1  signed overflow from the ADD/SUB path.
- br_valid  input  1  a branch (opcode 1100 or 1101) is being evaluated this cycle.
- br_cond  input  3  ccc branch condition field.
- flags  output  3  registered flags {Z,V,N}.
- br_taken  output  1  combinational branch decision.
- halted  output  1  sticky halt flag.

Behaviour:
- Reset: flags=3'b000; halted=0. br_taken=0 whenever br_valid=0.
- Update enable: upd = alu_valid & ~stall & ~halted.
- Opcode classes:
  - ADD (0000), SUB (0001): Z, V and N all written.
    - Z = (alu_result==0).
    - V = alu_ovfl.
    - N = alu_result[15].
  - XOR (0010), SLL (0100), SRA (0101), ROR (0110): only Z is written; V and N hold.
  - RED (0011), PADDSB (0111), LW, SW, LLB, LHB, B, BR, PCS (1000-1110): flags hold.
- ADD/SUB zero rule: Z is taken from the saturated result actually written back. Example: a saturated 0x7FFF gives Z=0, V=1, N=0.
- HLT (1111): when upd, halted<=1 on the next edge; flags hold. halted is sticky until rst_n is asserted.
- While halted=1: no flag updates, and br_taken=0.
- Flag update latency: 1 cycle. New flags are visible on `flags` after the rising edge where upd=1.
- Effective flags F seen by branch evaluation:
  - BYPASS=1 and upd=1 on a flag-writing opcode: F = next-state flags.
  - Otherwise: F = registered flags.
- br_taken = br_valid & ~halted & cond(br_cond, F):
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 & N=0.
  - 011 LT: N=1.
  - 100 GTE: Z=1 | (Z=0 & N=0).
  - 101 LTE: N=1 | Z=1.
  - 110 OVFL: V=1.
  - 111: unconditional, always 1.
- br_taken does not depend on stall. Fetch is responsible for gating the redirect during a stall.
- Simultaneous alu_valid and br_valid: legal. With BYPASS=0 the branch sees the old flags.
- Reset mid-operation: state clears immediately (asynchronous), independent of clk. An update pending on that edge is lost.
- X-safety: opcode is ignored when alu_valid=0. br_cond is ignored when br_valid=0.

Test Plan:
- Reset, then ADD with result 0x0000 and ovfl=0 -> next cycle flags={1,0,0}. Then br_valid=1, br_cond=001 -> br_taken=1; br_cond=000 -> 0.
- SUB with result 0x8000 and ovfl=1 -> flags={0,1,1}. Then XOR with result 0x0000 -> flags={1,1,1}, V and N unchanged. Then RED with result 0 -> flags unchanged.
- Sweep all 8 br_cond values over the flag patterns {0,0,0}, {1,0,0}, {0,0,1}, {0,1,0}. br_taken must match the condition list above; 111 is always 1.
- Forwarding and stall:
  - BYPASS=1: ADD with result 0x0000 and br_valid=1, br_cond=001 in the same cycle -> br_taken=1 in that cycle.
  - BYPASS=0: same stimulus -> br_taken follows the prior flags.
  - stall=1 during the ADD -> flags unchanged.
- HLT with alu_valid=1 -> halted=1 next cycle. A later ADD with result 0 leaves flags unchanged, and br_cond=111 gives br_taken=0.
- rst_n pulled low mid-cycle while halted=1 and flags={1,1,1} -> halted=0 and flags=000 immediately, without waiting for a clock edge.
